// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// mdu_pkg : shared types and constants for the EX-stage multiply/divide unit.
// Optional MADD/MADDU/MSUB/MSUBU op codes are enabled by macro MDU_MADD_EN.
// Rev 1.0
// ============================================================================
package mdu_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  typedef enum logic [OP_W-1:0] {
    MDU_NOP,
    MULT,
    MULTU,
    DIV,
    DIVU,
    MTHI,
    MTLO
`ifdef MDU_MADD_EN
    ,
    MADD,
    MADDU,
    MSUB,
    MSUBU
`endif
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// mdu_divider : iterative restoring radix-2 divider on operand magnitudes,
// one quotient bit per cycle, with sign fixup and divide-by-zero result.
// Rev 1.0
// ============================================================================
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [63:0] result_o
);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rem_q, quo_q, dvs_q, raw_a_q;
  logic             negq_q, negr_q, dz_q;

  logic [32:0] w_rem_sh, w_diff;
  logic [31:0] w_rem_n, w_quo_n, w_q_fix, w_r_fix;

  // quo_q starts as the dividend magnitude and shifts quotient bits in from the right
  assign w_rem_sh = {rem_q, quo_q[31]};
  assign w_diff   = w_rem_sh - {1'b0, dvs_q};
  assign w_rem_n  = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
  assign w_quo_n  = {quo_q[30:0], ~w_diff[32]};

  assign w_q_fix  = negq_q ? (32'd0 - w_quo_n) : w_quo_n;
  assign w_r_fix  = negr_q ? (32'd0 - w_rem_n) : w_rem_n;

  assign done_o   = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
  assign result_o = dz_q ? {raw_a_q, 32'hFFFF_FFFF} : {w_r_fix, w_q_fix};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_a_q <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= mag32(dividend_i, signed_i);
      dvs_q   <= mag32(divisor_i, signed_i);
      raw_a_q <= dividend_i;
      negq_q  <= signed_i & (dividend_i[31] ^ divisor_i[31]);
      negr_q  <= signed_i & dividend_i[31];
      dz_q    <= (divisor_i == 32'd0);
    end else if (busy_q) begin
      rem_q <= w_rem_n;
      quo_q <= w_quo_n;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : EX-stage MIPS multiply/divide unit producing {HI,LO} writes.
// Optional multiply-accumulate ops are enabled by macro MDU_MADD_EN.
// Rev 1.0
// ============================================================================
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs_data,
  input  logic [31:0]     rt_data,
  input  logic [63:0]     hilo_in,
  input  logic            flush,
  output logic            stall_req,
  output logic [1:0]      hilo_we,
  output logic [63:0]     hilo_wdata
);

  mdu_state_e  state_q, state_d;
  logic [31:0] a_q, b_q;
  logic        msign_q;
  logic [63:0] wdata_q, wdata_d;

  logic        w_go, w_accept_mul, w_msign;
  logic        w_div_start, w_div_abort, w_div_signed, w_div_done;
  logic [63:0] w_div_result, w_a64, w_b64, w_prod, w_mul_res;

`ifdef MDU_MADD_EN
  logic [63:0] acc_q;
  logic        sub_q, w_acc_en, w_sub;
`endif

  // Low 64 bits of a 64x64 product equal the 32x32 signed/unsigned product
  assign w_a64  = {{32{msign_q & a_q[31]}}, a_q};
  assign w_b64  = {{32{msign_q & b_q[31]}}, b_q};
  assign w_prod = w_a64 * w_b64;

`ifdef MDU_MADD_EN
  assign w_mul_res = sub_q ? (acc_q - w_prod) : (acc_q + w_prod);
`else
  assign w_mul_res = w_prod;
`endif

  assign w_go = start && !flush && !reset;

  always_comb begin
    state_d      = state_q;
    wdata_d      = wdata_q;
    stall_req    = 1'b0;
    hilo_we      = HILO_WE_NONE;
    hilo_wdata   = wdata_q;
    w_accept_mul = 1'b0;
    w_msign      = 1'b0;
    w_div_start  = 1'b0;
    w_div_abort  = 1'b0;
    w_div_signed = 1'b0;
`ifdef MDU_MADD_EN
    w_acc_en     = 1'b0;
    w_sub        = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_go) begin
          case (mdu_op_e'(op))
            MTHI: begin
              hilo_we    = HILO_WE_HI;
              hilo_wdata = {rs_data, hilo_in[31:0]};
              wdata_d    = hilo_wdata;
            end
            MTLO: begin
              hilo_we    = HILO_WE_LO;
              hilo_wdata = {hilo_in[63:32], rs_data};
              wdata_d    = hilo_wdata;
            end
            MULT, MULTU: begin
              stall_req    = 1'b1;
              state_d      = ST_MUL;
              w_accept_mul = 1'b1;
              w_msign      = (mdu_op_e'(op) == MULT);
            end
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: begin
              stall_req    = 1'b1;
              state_d      = ST_MUL;
              w_accept_mul = 1'b1;
              w_acc_en     = 1'b1;
              w_msign      = (mdu_op_e'(op) == MADD) || (mdu_op_e'(op) == MSUB);
              w_sub        = (mdu_op_e'(op) == MSUB) || (mdu_op_e'(op) == MSUBU);
            end
`endif
            DIV, DIVU: begin
              stall_req    = 1'b1;
              state_d      = ST_DIV;
              w_div_start  = 1'b1;
              w_div_signed = (mdu_op_e'(op) == DIV);
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall_req = 1'b1;
          state_d   = ST_DONE;
          wdata_d   = w_mul_res;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d     = ST_IDLE;
          w_div_abort = 1'b1;
        end else begin
          stall_req = 1'b1;
          if (w_div_done) begin
            state_d = ST_DONE;
            wdata_d = w_div_result;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        hilo_we = flush ? HILO_WE_NONE : HILO_WE_BOTH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      msign_q <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= '0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      if (w_accept_mul) begin
        a_q     <= rs_data;
        b_q     <= rt_data;
        msign_q <= w_msign;
`ifdef MDU_MADD_EN
        acc_q   <= w_acc_en ? hilo_in : 64'd0;
        sub_q   <= w_sub;
`endif
      end
    end
  end

  mdu_divider u_divider (
    .clk        (clk),
    .reset      (reset),
    .start_i    (w_div_start),
    .abort_i    (w_div_abort),
    .signed_i   (w_div_signed),
    .dividend_i (rs_data),
    .divisor_i  (rt_data),
    .done_o     (w_div_done),
    .result_o   (w_div_result)
  );

endmodule
`default_nettype wire
